// File: rtl/alu_issue_stage.sv
// Issue stage: 4-entry instruction queue feeding an external ALU, with two operand
// registers updated by host writes or by ALU writeback when an instruction issues.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic [31:0] wr_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instruction,
  output logic [31:0] regA,
  output logic [31:0] regB,
  input  logic [31:0] result_in,
  input  logic [2:0]  flags_in,
  input  logic        clr_flags,
  output logic [2:0]  sticky_flags,
  output logic [31:0] last_result,
  output logic [15:0] issue_count,
  output logic [2:0]  fifo_count
);

  logic [31:0] mem_q [4];
  logic [1:0]  wptr_q, wptr_d;
  logic [1:0]  rptr_q, rptr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] reg0_q, reg0_d;
  logic [31:0] reg1_q, reg1_d;
  logic [31:0] last_q, last_d;
  logic [15:0] icnt_q, icnt_d;
  logic [2:0]  sticky_q, sticky_d;

  logic        push, pop;
  logic [31:0] head;
  logic [5:0]  opcode, funct;
  logic        wb_en, dest_sel;

  assign in_ready  = (cnt_q != 3'd4);
  assign out_valid = (cnt_q != 3'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head        = mem_q[rptr_q];
  assign instruction = out_valid ? head : 32'h0;
  assign opcode      = head[31:26];
  assign funct       = head[5:0];

  // Only bit 0 of the register field matters: there are just two operand registers.
  assign dest_sel = (opcode == 6'h00) ? head[11] : head[16];

  always_comb begin
    wb_en = 1'b0;
    if (opcode == 6'h00) begin
      case (funct)
        6'h20, 6'h21, 6'h24, 6'h27, 6'h25, 6'h00, 6'h04, 6'h2A,
        6'h03, 6'h07, 6'h02, 6'h06, 6'h22, 6'h23, 6'h26: wb_en = 1'b1;
        default: wb_en = 1'b0;
      endcase
    end else begin
      case (opcode)
        6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E: wb_en = 1'b1;
        default: wb_en = 1'b0;
      endcase
    end
  end

  always_comb begin
    wptr_d   = push ? wptr_q + 2'd1 : wptr_q;
    rptr_d   = pop ? rptr_q + 2'd1 : rptr_q;
    cnt_d    = cnt_q + {2'b00, push} - {2'b00, pop};
    reg0_d   = reg0_q;
    reg1_d   = reg1_q;
    last_d   = last_q;
    icnt_d   = icnt_q;
    sticky_d = sticky_q;
    if (wr_en) begin
      if (wr_sel) reg1_d = wr_data;
      else        reg0_d = wr_data;
    end
    // Writeback is applied after the host write so it wins on a collision.
    if (pop) begin
      if (wb_en) begin
        if (dest_sel) reg1_d = result_in;
        else          reg0_d = result_in;
      end
      last_d   = result_in;
      icnt_d   = icnt_q + 16'd1;
      sticky_d = sticky_q | flags_in;
    end
    if (clr_flags) sticky_d = 3'b000;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_instr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= 2'd0;
      rptr_q   <= 2'd0;
      cnt_q    <= 3'd0;
      reg0_q   <= 32'h0;
      reg1_q   <= 32'h0;
      last_q   <= 32'h0;
      icnt_q   <= 16'h0;
      sticky_q <= 3'b000;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      reg0_q   <= reg0_d;
      reg1_q   <= reg1_d;
      last_q   <= last_d;
      icnt_q   <= icnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign regA         = reg0_q;
  assign regB         = reg1_q;
  assign sticky_flags = sticky_q;
  assign last_result  = last_q;
  assign issue_count  = icnt_q;
  assign fifo_count   = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small behavioural ALU closing the loop.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        wr_en;
  logic        wr_sel;
  logic [31:0] wr_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction;
  logic [31:0] regA, regB;
  logic [31:0] result_in;
  logic [2:0]  flags_in;
  logic        clr_flags;
  logic [2:0]  sticky_flags;
  logic [31:0] last_result;
  logic [15:0] issue_count;
  logic [2:0]  fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  alu_issue_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_ready     (in_ready),
    .wr_en        (wr_en),
    .wr_sel       (wr_sel),
    .wr_data      (wr_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .instruction  (instruction),
    .regA         (regA),
    .regB         (regB),
    .result_in    (result_in),
    .flags_in     (flags_in),
    .clr_flags    (clr_flags),
    .sticky_flags (sticky_flags),
    .last_result  (last_result),
    .issue_count  (issue_count),
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  // Environment ALU: operands come from the registers named by rs/rt bit 0.
  logic [31:0] a_op, b_op, sext, zext;
  always_comb begin
    a_op = instruction[21] ? regB : regA;
    b_op = instruction[16] ? regB : regA;
    sext = {{16{instruction[15]}}, instruction[15:0]};
    zext = {16'h0, instruction[15:0]};
    result_in = 32'h0;
    if (instruction[31:26] == 6'h00) begin
      case (instruction[5:0])
        6'h20, 6'h21: result_in = a_op + b_op;
        6'h22, 6'h23: result_in = a_op - b_op;
        6'h24:        result_in = a_op & b_op;
        6'h25:        result_in = a_op | b_op;
        default:      result_in = 32'h0;
      endcase
    end else begin
      case (instruction[31:26])
        6'h04, 6'h05: result_in = a_op - b_op;
        6'h0C:        result_in = a_op & zext;
        6'h0D:        result_in = a_op | zext;
        default:      result_in = a_op + sext;
      endcase
    end
    flags_in = {result_in == 32'h0, result_in[31], 1'b0};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic sel, input logic [31:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'h0; wr_en = 1'b0; wr_sel = 1'b0;
    wr_data = 32'h0; out_ready = 1'b0; clr_flags = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_fifo_count", {29'h0, fifo_count}, 32'd0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_regA", regA, 32'h0);
    chk("rst_issue_count", {16'h0, issue_count}, 32'd0);

    // Add: reg0 = 5 + 3, no same-cycle bypass
    host_wr(1'b0, 32'd5);
    host_wr(1'b1, 32'd3);
    chk("host_regA", regA, 32'd5);
    chk("host_regB", regB, 32'd3);
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h00011020;
    chk("no_bypass", {31'h0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("add_presented", instruction, 32'h00011020);
    chk("add_out_valid", {31'h0, out_valid}, 32'd1);
    tick();
    chk("add_reg0", regA, 32'd8);
    chk("add_issue_count", {16'h0, issue_count}, 32'd1);
    chk("add_last_result", last_result, 32'd8);
    chk("add_empty", {29'h0, fifo_count}, 32'd0);

    // Fill to 4 with out_ready low (non-writing sw), 5th push refused, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = 32'hAC000001 + i;
      tick();
    end
    chk("full_count", {29'h0, fifo_count}, 32'd4);
    chk("full_in_ready", {31'h0, in_ready}, 32'd0);
    in_instr = 32'hAC000005;
    out_ready = 1'b1;
    // Full + pop: push must still be refused this cycle
    chk("full_pop_head", instruction, 32'hAC000001);
    tick();
    in_valid = 1'b0;
    chk("full_pop_count", {29'h0, fifo_count}, 32'd3);
    for (int i = 1; i < 4; i++) begin
      chk("drain_order", instruction, 32'hAC000001 + i);
      tick();
    end
    chk("drain_empty", {31'h0, out_valid}, 32'd0);
    chk("drain_issue_count", {16'h0, issue_count}, 32'd5);
    chk("sw_no_wb_regA", regA, 32'd8);
    chk("sw_no_wb_regB", regB, 32'd3);
    chk("sw_last_result", last_result, 32'd12);

    // Simultaneous push and pop with 2 entries keeps the count
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hAC000010; tick();
    in_instr = 32'hAC000011; tick();
    out_ready = 1'b1; in_instr = 32'hAC000012; tick();
    in_valid = 1'b0;
    chk("pushpop_count", {29'h0, fifo_count}, 32'd2);
    chk("pushpop_head", instruction, 32'hAC000011);
    tick(); tick();
    chk("pushpop_drained", {29'h0, fifo_count}, 32'd0);
    chk("pushpop_issue_count", {16'h0, issue_count}, 32'd8);

    // beq with equal operands: zero flag sticks, no writeback
    host_wr(1'b0, 32'd7);
    host_wr(1'b1, 32'd7);
    in_valid = 1'b1; in_instr = 32'h10010004; tick();
    in_valid = 1'b0;
    tick();
    chk("beq_sticky", {29'h0, sticky_flags}, 32'd4);
    chk("beq_regA", regA, 32'd7);
    chk("beq_regB", regB, 32'd7);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("clr_sticky", {29'h0, sticky_flags}, 32'd0);
    // Clear in the same cycle as a flag-setting issue wins
    in_valid = 1'b1; in_instr = 32'h10010004; tick();
    in_valid = 1'b0; clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("clr_wins", {29'h0, sticky_flags}, 32'd0);
    chk("beq2_issue_count", {16'h0, issue_count}, 32'd10);

    // ori rt=1 (7 | 0xFF) collides with host write of reg1: writeback wins
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h340100FF; tick();
    in_valid = 1'b0;
    out_ready = 1'b1; wr_en = 1'b1; wr_sel = 1'b1; wr_data = 32'h55; tick();
    wr_en = 1'b0;
    chk("wb_wins_regB", regB, 32'hFF);
    chk("wb_wins_regA", regA, 32'd7);
    // ori rt=1 (7 | 0xF0) alongside host write to reg0: both land
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h340100F0; tick();
    in_valid = 1'b0;
    out_ready = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_data = 32'h11; tick();
    wr_en = 1'b0;
    chk("both_regB", regB, 32'hF7);
    chk("both_regA", regA, 32'h11);
    chk("ori_last_result", last_result, 32'hF7);

    // Stream non-writing instructions until issue_count wraps (12 issued so far)
    in_valid = 1'b1; in_instr = 32'hAC000000;
    for (int i = 0; i < 65536 - 12; i++) tick();
    in_valid = 1'b0;
    chk("wrap_ffff", {16'h0, issue_count}, 32'h0000FFFF);
    chk("wrap_pending", {29'h0, fifo_count}, 32'd1);
    tick();
    chk("wrap_zero", {16'h0, issue_count}, 32'd0);
    chk("wrap_sticky", {29'h0, sticky_flags}, 32'd0);

    // Asynchronous reset with two entries queued
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00011020; tick(); tick();
    in_valid = 1'b0;
    chk("pre_rst_count", {29'h0, fifo_count}, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", {29'h0, fifo_count}, 32'd0);
    chk("async_rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("async_rst_instruction", instruction, 32'h0);
    chk("async_rst_regA", regA, 32'h0);
    chk("async_rst_regB", regB, 32'h0);
    chk("async_rst_in_ready", {31'h0, in_ready}, 32'd1);
    chk("async_rst_last_result", last_result, 32'h0);
    // No writeback while reset is held, even with out_ready high
    out_ready = 1'b1; tick(); tick();
    chk("rst_hold_regA", regA, 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_empty", {31'h0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk in, rst in.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream instruction valid.
REQ-005 in_instr  input  32  MIPS instruction word.
REQ-006 in_ready  output  1  queue can accept; high when FIFO not full.
REQ-007 wr_en / wr_sel / wr_data  input  1/1/32  host register write to reg0 (wr_sel=0) or reg1 (wr_sel=1).
REQ-008 out_valid  output  1  head instruction presented to ALU.
REQ-009 out_ready  input  1  consumer accepts head this cycle.
REQ-010 instruction  output  32  FIFO head (0 when empty).
REQ-011 regA / regB  output  32/32  current reg0 / reg1 contents (ALU operand registers 00000 / 00001).
REQ-012 result_in / flags_in  input  32/3  combinational ALU result and flags {zero,neg,ovf} for presented instruction.
REQ-013 clr_flags  input  1  synchronous clear of sticky_flags.
REQ-014 sticky_flags  output  3  OR-accumulated flags_in over issued instructions.
REQ-015 last_result  output  32  result_in captured at last issue.
REQ-016 issue_count  output  16  issued-instruction counter.
REQ-017 fifo_count  output  3  FIFO occupancy, 0..4.

Function
REQ-018 FIFO SHALL be 4 entries deep, 2-bit read/write pointers wrapping 3->0.
REQ-019 Push SHALL occur on in_valid && in_ready; pop ("issue") on out_valid && out_ready.
REQ-020 out_valid SHALL equal (fifo_count != 0); no same-cycle bypass: push into empty FIFO gives out_valid=1 next cycle.
REQ-021 Simultaneous push and pop with 1..3 entries SHALL keep fifo_count unchanged; when full, in_ready=0 so push is refused even if a pop occurs.
REQ-022 Pop when empty SHALL not occur (out_valid=0); pointers/count never underflow.
REQ-023 On issue, destination SHALL be rd[0] for opcode 0x00, rt[0] otherwise.
REQ-024 Writeback SHALL occur on issue for R-type funct in {20,21,24,27,25,00,04,2A,03,07,02,06,22,23,26} and I-type opcodes {08,09,0C,0D,0E}; no write for 04,05,23,2B or any other opcode/funct.
REQ-025 Writeback SHALL store result_in into the destination register at the issuing clock edge; next presented instruction sees the updated regA/regB with no stall.
REQ-026 Host write and writeback to the same register in one cycle: writeback SHALL win; different registers: both SHALL take effect.
REQ-027 On every issue (writing or not), last_result <= result_in and issue_count increments, wrapping 0xFFFF->0x0000.
REQ-028 On issue, sticky_flags <= sticky_flags | flags_in; clr_flags same cycle SHALL win (result 3'b000).
REQ-029 All outputs SHALL be registered state or direct decodes of it; no combinational path from result_in/flags_in to any output.

Reset
REQ-030 rst high SHALL immediately clear FIFO pointers, fifo_count, reg0, reg1, last_result, issue_count, sticky_flags to 0; out_valid=0, instruction=0, in_ready=1.
REQ-031 Reset mid-operation SHALL discard all queued instructions; no writeback occurs on a cycle with rst high.

Verification
REQ-032 Reset then host writes reg0=5, reg1=3; push 0x00011020 (add rd=2) with out_ready=1, ALU model -> reg0=8, issue_count=1, last_result=8.
REQ-033 Push 4 instructions with out_ready=0 -> fifo_count=4, in_ready=0; 5th push ignored; release out_ready -> the 4 issue in order, one per cycle.
REQ-034 reg0=7, reg1=7; issue beq 0x10010004 -> flags_in=3'b100, no register change, sticky_flags=3'b100; then clr_flags -> 3'b000.
REQ-035 Same cycle: issue ori into rt=1 (result 0xFF) and host write reg1=0x55 -> reg1=0xFF; host write reg0=0x11 also applied.
REQ-036 Preload issue_count by issuing 65536 instructions -> wraps to 0; assert rst with 2 entries queued -> fifo_count=0, out_valid=0 asynchronously.
